fc_mvm_par: RTL
===============

Name: fc_mvm_par

Overview:
- Parametrised fully-connected layer: computes y = act(W·x) for an M×N signed weight matrix and an N-element input vector.
- P parallel MAC lanes compute P output rows per group.
- The input vector store is double-buffered, so vector k+1 streams in while vector k computes.
- Weights come from an external synchronous-read weight ROM port, one P-lane word per address. Sits in the layer chain in the same position as the existing single-lane fc blocks.

Parameters:
- M, 6, output rows; must be a multiple of P.
- N, 6, input vector length, ≥2.
- T, 8, signed data/weight width.
- P, 2, MAC lanes.
- RELU, 1, 1 = clamp negative results to 0.
- SAT, 1, 1 = saturate to T bits; 0 = keep the low T bits.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- input_valid  in  1  input element valid.
- input_ready  out  1  block can accept an input element.
- input_data  in  T  signed input element; x[0] first.
- w_addr  out  clog2((M/P)*N)  weight address = g*N + j.
- w_data  in  P*T  lane p (bits p*T +: T) = W[g*P+p][j]; valid the cycle after w_addr.
- output_valid  out  1  output element valid.
- output_ready  in  1  downstream accepts.
- output_data  out  T  signed result; rows 0..M-1 in order.

Behaviour:
- Reset (reset==0 at posedge): both banks empty, all FSMs idle, accumulators 0. Outputs: input_ready=0 during reset, then 1 the first cycle after; output_valid=0; output_data=0; w_addr=0. A partial vector or in-flight group is discarded; no output appears after reset until a full new vector arrives.
- Input handshake: an element is transferred when input_valid&&input_ready at posedge and written to the load bank at index 0..N-1.
  - After element N-1, the load bank is marked full and the load pointer toggles to the other bank.
  - input_ready = the current load bank is empty. It drops after the Nth element if the other bank is still full.
- Compute FSM: C_IDLE → C_ISSUE → C_TAIL → (C_HOLD) → C_ISSUE | C_IDLE.
  - C_IDLE: the compute bank is full → C_ISSUE, g=0, j=0.
  - C_ISSUE: w_addr=g*N+j; vector bank read at j (sync, 1-cycle). One cycle later, acc[p] += w_data[p]*x[j] (j=0 loads instead of adds). Stays N cycles.
  - The bank is freed (empty) in the cycle after the last issue of the last group (g=M/P-1, j=N-1). Input may refill it immediately.
  - C_TAIL: final accumulate. Next cycle, the results are moved into the output buffer if it is empty; otherwise → C_HOLD until it empties.
  - After the transfer: g<M/P-1 → C_ISSUE(g+1). Otherwise → C_IDLE, or directly C_ISSUE g=0 if the other bank is already full.
- Arithmetic: product 2T bits; accumulator A = 2T+clog2(N) bits signed, never overflows.
  - Post-process per lane: RELU then SAT.
  - SAT=1 clamps to [-2^(T-1), 2^(T-1)-1]; SAT=0 truncates.
- Output buffer: holds P results.
  - output_valid=1 while nonempty; output_data = lane 0 first.
  - Each output_valid&&output_ready advances one lane; after lane P-1 the buffer empties.
  - output_data and output_valid are held stable while output_ready=0.
  - Group-to-group ordering is strict: the buffer is refilled only when empty, and never in the same cycle as the last lane's handshake, so there is one bubble per group.
- Latency: with output_ready=1 and the block idle, the first output_valid is asserted N+2 cycles after the edge accepting the last element (8 at defaults).
- Simultaneous events:
  - A load-complete of one bank and a compute-free of the other in the same cycle are both honoured.
  - A new vector never overwrites a bank still being read.

Decomposition:
- Package fc_pkg holds:
  - the accumulator-width function acc_w(T,N);
  - the compute-state enum {C_IDLE,C_ISSUE,C_TAIL,C_HOLD};
  - the saturate/relu function sat_relu(acc, T, RELU, SAT).
- Sub-module fc_vec_buf: two N×T banks with load/compute pointers, full flags and a 1-cycle sync read. Instantiated once.
- The MAC lanes, compute FSM and output serializer stay in fc_mvm_par.

Test Plan:
- Basic (defaults): x=[1,2,3,4,5,6], row0 weights all 1, row1 all -1, rows 2..5 = e_r (row r: 1 at column r-2) -> outputs 21, 0, 1, 2, 3, 4; first output_valid exactly 8 cycles after the last input handshake.
- Saturation (RELU=0, SAT=1): x all 127, row0 all 127, row1 all -127 -> 127, -128. With SAT=0, row0 -> low 8 bits of 96774 = 6 (0x06).
- Backpressure: output_ready=0 for 20 cycles after the first output_valid -> output_data held at 21. A second vector is accepted (6 handshakes), then input_ready=0 until the first vector's bank frees. No data is lost or reordered across 3 back-to-back vectors.
- Streaming: 4 vectors with input_valid and output_ready always high -> 24 outputs matching the reference model, and input_ready never low longer than one compute pass.
- Reset mid-operation: assert reset after 3 inputs and again during an output burst -> output_valid=0 next cycle; the next full vector yields correct results with the nominal 8-cycle latency.
- P=3, M=6, N=4 build: the same golden-model comparison passes with random T-bit data. w_addr covers 0..7 exactly once per vector.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and arithmetic helpers for the parallel fully-connected layer.
// acc_w sizes the accumulator so an N-term sum of T x T products cannot overflow.
// sat_relu applies the optional ReLU then the optional saturation to a wide result.
package fc_pkg;

  typedef enum logic [1:0] {C_IDLE, C_ISSUE, C_TAIL, C_HOLD} c_state_t;

  function automatic int acc_w(input int t, input int n);
    return 2 * t + $clog2(n);
  endfunction

  // Caller keeps the low t bits: with sat=0 that is plain truncation.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] acc,
                                                  input int t, input bit relu,
                                                  input bit sat);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = acc;
    hi = (64'sd1 <<< (t - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (t - 1));
    if (relu && v < 0) v = '0;
    if (sat) begin
      if (v > hi) v = hi;
      else if (v < lo) v = lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/fc_mvm_par_vec_buf.sv
// Double-buffered input vector store: one bank loads while the other is read.
// Latency: load is a single write per element; compute read is registered (1 cycle).
// Backpressure: ld_rdy drops while the current load bank still holds an unconsumed vector.
// Ports: ld_* element load handshake, cmp_full/cmp_free compute-bank status and release,
//        rd_idx/rd_dat synchronous read of the compute bank.
module fc_vec_buf #(
  parameter int N  = 6,
  parameter int T  = 8,
  parameter int JW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_vld,
  input  logic [T-1:0]  ld_dat,
  output logic          ld_rdy,
  output logic          cmp_full,
  input  logic          cmp_free,
  input  logic [JW-1:0] rd_idx,
  output logic [T-1:0]  rd_dat
);

  logic [T-1:0]  mem [2][N];
  logic [1:0]    full;
  logic          ld_ptr;
  logic          cmp_ptr;
  logic [JW-1:0] ld_idx;
  logic          ld_fire;

  // Held low while reset is asserted so nothing is accepted during reset.
  assign ld_rdy   = reset && !full[ld_ptr];
  assign cmp_full = full[cmp_ptr];
  assign ld_fire  = ld_vld && ld_rdy;

  // Load only targets an empty bank and free only a full one, so the two
  // updates below never touch the same flag in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      full    <= '0;
      ld_ptr  <= 1'b0;
      cmp_ptr <= 1'b0;
      ld_idx  <= '0;
    end else begin
      if (ld_fire) begin
        if (ld_idx == JW'(N - 1)) begin
          ld_idx       <= '0;
          full[ld_ptr] <= 1'b1;
          ld_ptr       <= ~ld_ptr;
        end else begin
          ld_idx <= ld_idx + 1'b1;
        end
      end
      if (cmp_free) begin
        full[cmp_ptr] <= 1'b0;
        cmp_ptr       <= ~cmp_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_fire) mem[ld_ptr][ld_idx] <= ld_dat;
    rd_dat <= mem[cmp_ptr][rd_idx];
  end

endmodule

// File: rtl/fc_mvm_par.sv
// Fully-connected layer y = act(W.x) with P parallel MAC lanes, rows emitted 0..M-1.
// Latency: first output N+2 cycles after the last input element when idle.
// Backpressure: output_ready stalls the serializer, which stalls compute; input stalls when both banks full.
// Ports: input_* element stream in, w_addr/w_data sync weight ROM (P lanes per word),
//        output_* result stream out.
module fc_mvm_par import fc_pkg::*; #(
  parameter int M    = 6,
  parameter int N    = 6,
  parameter int T    = 8,
  parameter int P    = 2,
  parameter bit RELU = 1'b1,
  parameter bit SAT  = 1'b1,
  localparam int G   = M / P,
  localparam int AW  = ($clog2(G * N) > 0) ? $clog2(G * N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          input_valid,
  output logic          input_ready,
  input  logic [T-1:0]  input_data,
  output logic [AW-1:0] w_addr,
  input  logic [P*T-1:0] w_data,
  output logic          output_valid,
  input  logic          output_ready,
  output logic [T-1:0]  output_data
);

  localparam int GW = ($clog2(G) > 0) ? $clog2(G) : 1;
  localparam int JW = ($clog2(N) > 0) ? $clog2(N) : 1;
  localparam int OW = ($clog2(P) > 0) ? $clog2(P) : 1;
  localparam int A  = acc_w(T, N);

  c_state_t              state;
  logic [GW-1:0]         g;
  logic [JW-1:0]         j;
  logic                  iss_vld;
  logic                  iss_first;
  logic signed [A-1:0]   acc    [P];
  logic signed [A-1:0]   acc_nx [P];
  logic signed [2*T-1:0] prod   [P];
  logic [T-1:0]          res    [P];
  logic [T-1:0]          ob     [P];
  logic                  ob_full;
  logic [OW-1:0]         ob_idx;
  logic [T-1:0]          x_rd;
  logic                  cmp_full;
  logic                  cmp_free;
  logic                  xfer;

  // Release the vector bank on the last issue of the last group; its final
  // element is captured into x_rd on that same edge.
  assign cmp_free = (state == C_ISSUE) && (g == GW'(G - 1)) && (j == JW'(N - 1));
  assign w_addr   = (state == C_ISSUE) ? AW'(int'(g) * N + int'(j)) : '0;
  assign xfer     = ((state == C_TAIL) || (state == C_HOLD)) && !ob_full;

  assign output_valid = ob_full;
  assign output_data  = ob[ob_idx];

  fc_vec_buf #(.N(N), .T(T), .JW(JW)) u_vec_buf (
    .clk      (clk),
    .reset    (reset),
    .ld_vld   (input_valid),
    .ld_dat   (input_data),
    .ld_rdy   (input_ready),
    .cmp_full (cmp_full),
    .cmp_free (cmp_free),
    .rd_idx   (j),
    .rd_dat   (x_rd)
  );

  // Weight and vector operands arrive one cycle after issue; the final term
  // lands during C_TAIL, so the output buffer is fed from acc_nx to save a cycle.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      prod[p] = $signed({{T{w_data[p*T+T-1]}}, w_data[p*T +: T]}) *
                $signed({{T{x_rd[T-1]}}, x_rd});
      acc_nx[p] = acc[p];
      if (iss_vld)
        acc_nx[p] = (iss_first ? '0 : acc[p]) + {{(A-2*T){prod[p][2*T-1]}}, prod[p]};
      res[p] = T'(sat_relu({{(64-A){acc_nx[p][A-1]}}, acc_nx[p]}, T, RELU, SAT));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= C_IDLE;
      g         <= '0;
      j         <= '0;
      iss_vld   <= 1'b0;
      iss_first <= 1'b0;
      ob_full   <= 1'b0;
      ob_idx    <= '0;
      for (int p = 0; p < P; p++) begin
        acc[p] <= '0;
        ob[p]  <= '0;
      end
    end else begin
      iss_vld   <= (state == C_ISSUE);
      iss_first <= (j == '0);
      for (int p = 0; p < P; p++) acc[p] <= acc_nx[p];

      case (state)
        C_IDLE: begin
          if (cmp_full) begin
            state <= C_ISSUE;
            g     <= '0;
            j     <= '0;
          end
        end
        C_ISSUE: begin
          if (j == JW'(N - 1)) begin
            j     <= '0;
            state <= C_TAIL;
          end else begin
            j <= j + 1'b1;
          end
        end
        C_TAIL, C_HOLD: begin
          if (xfer) begin
            if (g != GW'(G - 1)) begin
              g     <= g + 1'b1;
              state <= C_ISSUE;
            end else begin
              g     <= '0;
              state <= cmp_full ? C_ISSUE : C_IDLE;
            end
          end else begin
            state <= C_HOLD;
          end
        end
        default: state <= C_IDLE;
      endcase

      // Refill only from empty, so the last-lane handshake always costs a bubble.
      if (xfer) begin
        for (int p = 0; p < P; p++) ob[p] <= res[p];
        ob_full <= 1'b1;
        ob_idx  <= '0;
      end else if (ob_full && output_ready) begin
        if (ob_idx == OW'(P - 1)) ob_full <= 1'b0;
        else ob_idx <= ob_idx + 1'b1;
      end
    end
  end

endmodule
